// File: rtl/nibble_serializer_if.sv
// Signal bundle between the word source, the serializer and the downstream 4:1 mux.
// Handshake: a word moves on a rising edge where din_valid && din_ready; din_valid may not depend on din_ready.
interface nibble_serializer_if;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] i;
    logic [1:0] s;
    logic       F;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    modport master (
        output din, din_valid, F,
        input  din_ready, i, s, ser_bit, ser_valid, ser_last, busy
    );

    modport slave (
        input  din, din_valid, F,
        output din_ready, i, s, ser_bit, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/nibble_serializer.sv
// Drives a 4:1 mux with a held word and a stepping select, and registers the mux
// output as a 4-bit serial stream with valid/last flags; optional idle gap per word.
module nibble_serializer #(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serializer_if.slave  bus,
    output logic [1:0]          dbg_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [1:0] START_IDX = MSB_FIRST ? 2'd3 : 2'd0;
    localparam bit         HAS_GAP   = (GAP != 0);
    localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    logic [1:0] state;
    logic [1:0] cnt;
    logic [3:0] gcnt;
    logic [3:0] i_q;
    logic [1:0] s_q;
    logic       ser_bit_q;
    logic       ser_valid_q;
    logic       ser_last_q;
    logic       ready;
    logic       xfer;
    logic [1:0] next_idx;

    assign next_idx = MSB_FIRST ? (s_q - 2'd1) : (s_q + 2'd1);

    // Ready is also offered on the last bit so GAP=0 streams without a bubble.
    always_comb begin
        ready = 1'b0;
        if (rst_n) begin
            if (state == ST_IDLE)
                ready = 1'b1;
            else if (state == ST_SHIFT && cnt == 2'd3 && !HAS_GAP)
                ready = 1'b1;
        end
    end

    assign xfer = bus.din_valid && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 2'd0;
            gcnt        <= 4'd0;
            i_q         <= 4'd0;
            s_q         <= START_IDX;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    if (xfer) begin
                        i_q   <= bus.din;
                        s_q   <= START_IDX;
                        cnt   <= 2'd0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // F reflects the select driven this cycle, so the bit lands one cycle later.
                    ser_bit_q   <= bus.F;
                    ser_valid_q <= 1'b1;
                    ser_last_q  <= (cnt == 2'd3);
                    if (cnt != 2'd3) begin
                        cnt <= cnt + 2'd1;
                        s_q <= next_idx;
                    end else if (xfer) begin
                        i_q <= bus.din;
                        s_q <= START_IDX;
                        cnt <= 2'd0;
                    end else if (HAS_GAP) begin
                        gcnt  <= GAP_LOAD;
                        s_q   <= START_IDX;
                        state <= ST_GAP;
                    end else begin
                        s_q   <= START_IDX;
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    if (gcnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        gcnt <= gcnt - 4'd1;
                end
                default: begin
                    ser_valid_q <= 1'b0;
                    ser_last_q  <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.din_ready = ready;
    assign bus.i         = i_q;
    assign bus.s         = s_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.busy      = (state != ST_IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: three instances (LSB-first, MSB-first, GAP=3) each behind a
// behavioural mux, compared every cycle against a word-level model and a bit scoreboard.
module tb_nibble_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    nibble_serializer_if if0 ();
    nibble_serializer_if if1 ();
    nibble_serializer_if if2 ();

    logic [3:0] din_d [3];
    logic       vld_d [3];
    logic       rst_d [3];
    logic [1:0] st0, st1, st2;

    initial begin
        for (int k = 0; k < 3; k++) begin
            din_d[k] = 4'd0;
            vld_d[k] = 1'b0;
            rst_d[k] = 1'b0;
        end
    end

    nibble_serializer #(.MSB_FIRST(1'b0), .GAP(0)) u0 (.clk(clk), .rst_n(rst_d[0]), .bus(if0), .dbg_state(st0));
    nibble_serializer #(.MSB_FIRST(1'b1), .GAP(0)) u1 (.clk(clk), .rst_n(rst_d[1]), .bus(if1), .dbg_state(st1));
    nibble_serializer #(.MSB_FIRST(1'b0), .GAP(3)) u2 (.clk(clk), .rst_n(rst_d[2]), .bus(if2), .dbg_state(st2));

    // Behavioural 4:1 muxes and input drive
    assign if0.F = if0.i[if0.s];
    assign if1.F = if1.i[if1.s];
    assign if2.F = if2.i[if2.s];
    assign if0.din = din_d[0];
    assign if1.din = din_d[1];
    assign if2.din = din_d[2];
    assign if0.din_valid = vld_d[0];
    assign if1.din_valid = vld_d[1];
    assign if2.din_valid = vld_d[2];

    logic       rdy_o [3], sv_o [3], sl_o [3], sb_o [3], busy_o [3];
    logic [3:0] i_o [3];
    logic [1:0] s_o [3];
    assign rdy_o[0] = if0.din_ready; assign rdy_o[1] = if1.din_ready; assign rdy_o[2] = if2.din_ready;
    assign sv_o[0]  = if0.ser_valid; assign sv_o[1]  = if1.ser_valid; assign sv_o[2]  = if2.ser_valid;
    assign sl_o[0]  = if0.ser_last;  assign sl_o[1]  = if1.ser_last;  assign sl_o[2]  = if2.ser_last;
    assign sb_o[0]  = if0.ser_bit;   assign sb_o[1]  = if1.ser_bit;   assign sb_o[2]  = if2.ser_bit;
    assign busy_o[0] = if0.busy;     assign busy_o[1] = if1.busy;     assign busy_o[2] = if2.busy;
    assign i_o[0]   = if0.i;         assign i_o[1]   = if1.i;         assign i_o[2]   = if2.i;
    assign s_o[0]   = if0.s;         assign s_o[1]   = if1.s;         assign s_o[2]   = if2.s;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gapk(input int k);
        return (k == 2) ? 3 : 0;
    endfunction

    function automatic int idx(input int k, input int p);
        return (k == 1) ? 3 - p : p;
    endfunction

    int         bl [3] = '{0, 0, 0};       // cycles until the word's SHIFT+GAP time is used up
    logic [3:0] word [3] = '{4'd0, 4'd0, 4'd0};
    bit         esv [3] = '{0, 0, 0};
    bit         rst_flag [3] = '{0, 0, 0};
    logic [1:0] exp_q [3][$];              // {bit, last}

    function automatic bit model_ready(input int k);
        return rst_d[k] && (bl[k] == 0 || (gapk(k) == 0 && bl[k] == 1));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_d[k]) begin
                bl[k] = 0;
                word[k] = 4'd0;
                esv[k] = 1'b0;
                rst_flag[k] = 1'b1;
                exp_q[k].delete();
            end else begin
                bit acc;
                acc = vld_d[k] && model_ready(k);
                rst_flag[k] = 1'b0;
                esv[k] = (bl[k] > gapk(k));
                if (bl[k] > 0) bl[k] = bl[k] - 1;
                if (acc) begin
                    bl[k] = 4 + gapk(k);
                    word[k] = din_d[k];
                    for (int p = 0; p < 4; p++)
                        exp_q[k].push_back({din_d[k][idx(k, p)], (p == 3) ? 1'b1 : 1'b0});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic last_bit [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int p;
            logic [1:0] es;
            logic [1:0] e;
            if (rst_flag[k]) last_bit[k] = 1'b0;
            p  = 4 + gapk(k) - bl[k];
            es = (bl[k] > gapk(k)) ? 2'(idx(k, p)) : 2'(idx(k, 0));
            chk("din_ready", k, 8'(rdy_o[k]), 8'(model_ready(k)));
            chk("busy", k, 8'(busy_o[k]), 8'(bl[k] > 0));
            chk("s", k, 8'(s_o[k]), 8'(es));
            chk("i", k, 8'(i_o[k]), 8'(word[k]));
            chk("ser_valid", k, 8'(sv_o[k]), 8'(esv[k]));
            if (sv_o[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("unexpected_bit", k, 8'(sb_o[k]), 8'hFF);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("ser_bit", k, 8'(sb_o[k]), 8'(e[1]));
                    chk("ser_last", k, 8'(sl_o[k]), 8'(e[0]));
                    last_bit[k] = e[1];
                end
            end else begin
                chk("ser_last_idle", k, 8'(sl_o[k]), 8'd0);
                chk("ser_bit_hold", k, 8'(sb_o[k]), 8'(last_bit[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input logic [3:0] w, input bit keep);
        bit r;
        int n;
        n = 0;
        din_d[k] = w;
        vld_d[k] = 1'b1;
        r = 1'b0;
        while (!r && n < 40) begin
            r = model_ready(k);
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) chk("accept_timeout", k, 8'(n), 8'd0);
        if (!keep) vld_d[k] = 1'b0;
    endtask

    task automatic reset_pulse(input int k, input int n);
        rst_d[k] = 1'b0;
        cycles(n);
        rst_d[k] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        for (int k = 0; k < 3; k++) rst_d[k] = 1'b1;
        cycles(10);                          // idle after reset
        send(0, 4'b1011, 1'b0);              // LSB first: 1,1,0,1
        cycles(8);
        send(1, 4'b0010, 1'b0);              // MSB first: 0,0,1,0
        cycles(6);
        send(0, 4'b0001, 1'b1);              // back-to-back, no bubble
        send(0, 4'b1110, 1'b0);
        cycles(8);
        send(2, 4'b1010, 1'b1);              // second word waits out the gap
        send(2, 4'b0101, 1'b0);
        cycles(12);
        send(0, 4'b1111, 1'b0);              // reset after the 2nd bit
        cycles(1);
        @(posedge clk);
        #1;
        rst_d[0] = 1'b0;
        cycles(1);
        rst_d[0] = 1'b1;
        cycles(4);
        for (int t = 0; t < 80; t++) begin
            int k;
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 11) == 0) begin
                reset_pulse(k, int'($urandom_range(1, 2)));
            end else begin
                send(k, 4'($urandom), 1'($urandom_range(0, 1)));
            end
            for (int j = 0; j < 3; j++)
                if (!vld_d[j]) din_d[j] = 4'($urandom);
            cycles(int'($urandom_range(0, 3)));
        end
        for (int k = 0; k < 3; k++) vld_d[k] = 1'b0;
        cycles(20);
        for (int k = 0; k < 3; k++)
            chk("drain", k, 8'(exp_q[k].size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

- Sequencing stage that sits directly upstream of the 4:1 mux (`mux_4x1`).
- Accepts a 4-bit word over a valid/ready handshake and holds it on the mux data inputs `i`.
- Steps the mux select `s` through all four positions, one per clock.
- Registers the returned mux output `F` as a serial bit stream with valid and last flags. This turns the combinational mux into a 4-cycle parallel-to-serial converter.

## Interface

Parameters:
- MSB_FIRST, default 0: 0 gives select order 0,1,2,3; 1 gives select order 3,2,1,0.
- GAP, default 0: idle cycles inserted after each word (0..15). Back-to-back words are possible only when GAP=0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- din  in  4  parallel word to serialize.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle; transfer when din_valid && din_ready at a rising edge.
- i  out  4  registered word, drives mux i[3:0].
- s  out  2  registered select, drives mux s[1:0].
- F  in  1  mux output, combinational from i/s.
- ser_bit  out  1  registered sample of F.
- ser_valid  out  1  ser_bit holds a new sample this cycle.
- ser_last  out  1  ser_bit is the 4th bit of a word.
- busy  out  1  state != IDLE.

## Operation

- State machine has three states: IDLE, SHIFT, GAP. A 2-bit bit counter cnt and a 4-bit gap counter gcnt support it.
- Start index is 0 if MSB_FIRST=0, 3 if MSB_FIRST=1. Next index is +1 or -1 respectively.
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, i=0, s=start index, cnt=0, gcnt=0;
  - ser_bit=0, ser_valid=0, ser_last=0.
  - Reset overrides any handshake in the same cycle.
- din_ready is combinational. It is 1 in IDLE, and also 1 in SHIFT when cnt==3 and GAP==0. It is 0 otherwise, and 0 while rst_n=0.
- IDLE:
  - On transfer: i<=din, s<=start index, cnt<=0, go to SHIFT.
  - Without transfer: hold i and s.
- SHIFT, every cycle:
  - ser_bit<=F, ser_valid<=1, ser_last<=(cnt==3).
  - If cnt<3: cnt<=cnt+1 and s<=next index.
  - If cnt==3 and a transfer occurs (GAP==0 only): i<=din, s<=start index, cnt<=0, stay in SHIFT.
  - If cnt==3, GAP==0 and no transfer: go to IDLE and set s<=start index.
  - If cnt==3 and GAP>0: go to GAP with gcnt<=GAP-1 and s<=start index.
- GAP:
  - gcnt decrements each cycle; go to IDLE when gcnt==0.
  - ser_valid=0 and din_ready=0 throughout.
- In IDLE and GAP, ser_valid and ser_last are 0 and ser_bit holds its last value.
- i holds the last word until the next transfer; it is never cleared except by reset.
- din changing while din_ready=0 has no effect.

## Timing

- Word accepted at edge E0. s takes indices k0..k3 in the cycles after E0..E3.
- The matching bit appears on ser_bit after edges E1..E4, one cycle behind its select. ser_last is high with the bit after E4.
- Latency from accept to first ser_valid is 1 cycle. A word occupies exactly 4 ser_valid cycles.
- With GAP=0 and din_valid held high, ser_valid stays continuously high: 4 bits per word, no bubble.
- Without back-to-back input, the per-word period is 4 + GAP + 1 cycles (IDLE accept cycle included).
- Reset mid-word: at the reset edge all outputs go to reset values. The partial word is discarded with no ser_last, and the first cycle after reset is IDLE with din_ready=1.

## Test plan

- Reset, then din=4'b1011 with MSB_FIRST=0, GAP=0:
  - s=0,1,2,3 on consecutive cycles;
  - ser_bit=1,1,0,1 with ser_valid high for 4 cycles;
  - ser_last only on the 4th bit; busy falls afterwards.
- MSB_FIRST=1, din=4'b0010:
  - s=3,2,1,0;
  - ser_bit=0,0,1,0, with ser_last on the final 0.
- GAP=0, din_valid held high:
  - words 4'b0001 then 4'b1110 produce ser_bit=1,0,0,0,0,1,1,1 with no ser_valid gap;
  - din_ready pulses at the cnt==3 cycle;
  - ser_last on bits 4 and 8.
- GAP=3, two words:
  - 3 cycles of ser_valid=0 and din_ready=0 after ser_last, then 1 IDLE cycle before the second word is accepted;
  - din held during GAP is ignored until din_ready=1.
- rst_n=0 asserted after the 2nd bit of 4'b1111:
  - next cycle ser_valid=0, ser_last=0, i=0, s=0, busy=0, din_ready=1;
  - no ser_last is ever emitted for that word.
- din_valid=0 for 10 cycles after reset:
  - ser_valid=0, s=0 and busy=0 throughout;
  - the first din_valid pulse is accepted in the same cycle.
